// File: rtl/i2c_target.sv
// I2C target responder with a small byte-wide register file.
//
// Bus side: the initiator writes a register pointer, then either writes data bytes
// (auto-incrementing pointer) or issues a repeated START and reads bytes back.
// Host side: direct single-cycle write and registered read of the same registers.
//
// Ports:
//   clk, reset        system clock (>= 8x SCL), synchronous active-high reset
//   scl_in, sda_in    raw asynchronous bus pin levels
//   sda_oe            1 pulls SDA low (open drain), 0 releases it
//   host_addr/wdata/we, host_rdata   host register access, 1-cycle read latency
//   busy              set by an address match, cleared by STOP or reset
//   wr_strobe/wr_index   one-cycle pulse and register index per bus-written byte
module i2c_target #(
  parameter logic [6:0]  ADDRESS  = 7'h50,
  parameter int unsigned REG_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe,
  input  logic [REG_BITS-1:0] host_addr,
  input  logic [7:0]          host_wdata,
  input  logic                host_we,
  output logic [7:0]          host_rdata,
  output logic                busy,
  output logic                wr_strobe,
  output logic [REG_BITS-1:0] wr_index
);

  localparam int unsigned NumRegs = 2 ** REG_BITS;

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
  } state_e;

  // Input conditioning: 2-FF synchronizer plus a previous-value stage per pin.
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high on both samples so an SDA change next to an SCL edge is not a condition.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [REG_BITS-1:0] ptr_q, ptr_d;
  logic [REG_BITS-1:0] wr_index_q, wr_index_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                nack_q, nack_d;
  logic                wr_strobe_q;
  logic                bus_we;
  logic [7:0]          host_rdata_q;
  logic [7:0]          regs_q [NumRegs];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      ptr_q        <= '0;
      wr_index_q   <= '0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      nack_q       <= 1'b1;
      wr_strobe_q  <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      wr_index_q   <= wr_index_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      nack_q       <= nack_d;
      wr_strobe_q  <= bus_we;
      host_rdata_q <= regs_q[host_addr];
    end
  end

  // Register file is never cleared; the host write is applied last so it wins a collision.
  always_ff @(posedge clk) begin
    if (bus_we && !reset) regs_q[ptr_q] <= shift_q;
    if (host_we) regs_q[host_addr] <= host_wdata;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    wr_index_d = wr_index_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    nack_d     = nack_q;
    bus_we     = 1'b0;

    if (stop_det) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else if (start_det) begin
      state_d  = StAddr;
      sda_oe_d = 1'b0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: sda_oe_d = 1'b0;

        StAddr, StPtr, StWdata: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (state_q == StAddr) begin
              if (shift_q[7:1] == ADDRESS) begin
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                state_d  = StAddrAck;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = StIgnore;
              end
            end else if (state_q == StPtr) begin
              ptr_d    = shift_q[REG_BITS-1:0];
              sda_oe_d = 1'b1;
              state_d  = StPtrAck;
            end else begin
              bus_we     = 1'b1;
              wr_index_d = ptr_q;
              ptr_d      = ptr_q + 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = StWdataAck;
            end
          end
        end

        StAddrAck: begin
          if (scl_fall) begin
            cnt_d = '0;
            // R/W bit is still in shift_q[0]: nothing shifts during the ACK slot.
            if (!shift_q[0]) begin
              sda_oe_d = 1'b0;
              state_d  = StPtr;
            end else begin
              shift_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
              state_d  = StRdata;
            end
          end
        end

        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = StWdata;
          end
        end

        StRdata: begin
          if (scl_fall) begin
            if (cnt_q == 4'd7) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 1'b1;
              cnt_d    = '0;
              nack_d   = 1'b1;
              state_d  = StRdataAck;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end

        StRdataAck: begin
          if (scl_rise) begin
            nack_d = sda_s;
          end else if (scl_fall) begin
            cnt_d = '0;
            if (!nack_q) begin
              shift_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
              state_d  = StRdata;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StIgnore;
            end
          end
        end

        default: begin
          sda_oe_d = 1'b0;
          state_d  = StIdle;
        end
      endcase
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_index   = wr_index_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged initiator, open-drain bus model and a
// transaction-level register-file model (array + pointer).
module tb_i2c_target;

  localparam int T = 5;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       scl_in, sda_in;
  logic       sda_oe;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_we;
  logic [7:0] host_rdata;
  logic       busy;
  logic       wr_strobe;
  logic [3:0] wr_index;

  always #5 clk = ~clk;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target #(.ADDRESS(7'h50), .REG_BITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .host_rdata (host_rdata),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .wr_index   (wr_index)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitors.
  int         strobe_cnt = 0;
  int         oe_seen = 0;
  int         busy_seen = 0;
  int         oe_hi_changes = 0;
  logic [3:0] last_idx = '0;
  logic       oe_prev = 1'b0;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      last_idx = wr_index;
    end
    if (sda_oe) oe_seen++;
    if (busy) busy_seen++;
    if (!reset && sda_oe !== oe_prev && scl_m) oe_hi_changes++;
    oe_prev = sda_oe;
  end

  // Reference model.
  logic [7:0] m_regs [16];
  logic [3:0] m_ptr;
  logic [3:0] m_last;
  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    repeat (T) @(negedge clk); sda_m = b;
    repeat (T) @(negedge clk); scl_m = 1'b1;
    repeat (T) @(negedge clk); s = sda_in;
    repeat (T) @(negedge clk); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    repeat (T) @(negedge clk); sda_m = 1'b1;
    repeat (T) @(negedge clk); scl_m = 1'b1;
    repeat (T) @(negedge clk); sda_m = 1'b0;
    repeat (T) @(negedge clk); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    repeat (T) @(negedge clk); sda_m = 1'b0;
    repeat (T) @(negedge clk); scl_m = 1'b1;
    repeat (T) @(negedge clk); sda_m = 1'b1;
    repeat (2 * T) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
    bit_cycle(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      d[i] = s;
    end
    bit_cycle(~master_ack, s);
  endtask

  // Pointer byte then n data bytes from wbuf.
  task automatic bus_write(input logic [7:0] dev, input logic [7:0] p, input int n,
                           input string tag);
    logic a, match;
    int   s0, oe0, b0;
    match = (dev[7:1] == 7'h50) && !dev[0];
    s0 = strobe_cnt; oe0 = oe_seen; b0 = busy_seen;
    i2c_start();
    write_byte(dev, a);
    check({tag, " addr ack"}, a, match);
    write_byte(p, a);
    check({tag, " ptr ack"}, a, match);
    if (match) m_ptr = p[3:0];
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], a);
      check({tag, " data ack"}, a, match);
      if (match) begin
        m_regs[m_ptr] = wbuf[i];
        m_last = m_ptr;
        m_ptr++;
      end
    end
    if (match) begin
      check({tag, " busy during"}, busy, 1);
    end else begin
      check({tag, " sda_oe never driven"}, oe_seen - oe0, 0);
      check({tag, " busy never set"}, busy_seen - b0, 0);
    end
    i2c_stop();
    check({tag, " busy after stop"}, busy, 0);
    check({tag, " strobe count"}, strobe_cnt - s0, match ? n : 0);
    if (match && n > 0) check({tag, " wr_index"}, last_idx, m_last);
  endtask

  // Optional pointer set + repeated START, then n reads (ACK all but the last).
  task automatic bus_read(input logic set_ptr, input logic [7:0] p, input int n,
                          input string tag);
    logic a;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'hA0, a);
      check({tag, " addr ack"}, a, 1);
      write_byte(p, a);
      check({tag, " ptr ack"}, a, 1);
      m_ptr = p[3:0];
      i2c_start();
    end
    write_byte(8'hA1, a);
    check({tag, " read addr ack"}, a, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, d);
      rbuf[i] = d;
      check({tag, " read data"}, d, m_regs[m_ptr]);
      m_ptr++;
    end
    repeat (6) @(negedge clk);
    check({tag, " released after nack"}, sda_oe, 0);
    i2c_stop();
    check({tag, " busy after stop"}, busy, 0);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
    int         exp_strobes;
    logic [3:0] exp_idx;
    logic [7:0] exp_reg;  // value of reg[ptr & 15] afterwards; used only when exp_ack
  } wvec_t;

  wvec_t tbl [4];

  initial begin
    logic [7:0] d;
    logic       a, s;
    int         s0;

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    host_addr = '0; host_wdata = '0; host_we = 1'b0;
    m_ptr = '0; m_last = '0;
    repeat (4) @(negedge clk);
    check("reset sda_oe", sda_oe, 0);
    check("reset busy", busy, 0);
    check("reset wr_strobe", wr_strobe, 0);
    check("reset wr_index", wr_index, 0);
    check("reset host_rdata", host_rdata, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 16; i++) host_write(4'(i), 8'($urandom));

    // Table-driven single-byte writes.
    tbl[0] = '{8'hA0, 8'h03, 8'h5A, 1'b1, 1, 4'd3, 8'h5A};
    tbl[1] = '{8'hA2, 8'h00, 8'hFF, 1'b0, 0, 4'd0, 8'h00};
    tbl[2] = '{8'hA0, 8'hF7, 8'h99, 1'b1, 1, 4'd7, 8'h99};
    tbl[3] = '{8'h20, 8'h01, 8'h42, 1'b0, 0, 4'd0, 8'h00};
    for (int i = 0; i < 4; i++) begin
      s0 = strobe_cnt;
      wbuf[0] = tbl[i].data;
      bus_write(tbl[i].dev, tbl[i].ptr, 1, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d strobes", i), strobe_cnt - s0, tbl[i].exp_strobes);
      if (tbl[i].exp_ack) check($sformatf("tbl%0d idx", i), last_idx, tbl[i].exp_idx);
      host_read(tbl[i].ptr[3:0], d);
      if (tbl[i].exp_ack) check($sformatf("tbl%0d reg", i), d, tbl[i].exp_reg);
      else check($sformatf("tbl%0d reg unchanged", i), d, m_regs[tbl[i].ptr[3:0]]);
    end

    // Burst write wrapping past the last register.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    bus_write(8'hA0, 8'h0E, 3, "wrap");
    host_read(4'd14, d); check("wrap reg14", d, 8'h11);
    host_read(4'd15, d); check("wrap reg15", d, 8'h22);
    host_read(4'd0, d);  check("wrap reg0", d, 8'h33);

    // Repeated-start read of two bytes.
    host_write(4'd5, 8'hC3);
    host_write(4'd6, 8'h3C);
    bus_read(1'b1, 8'h05, 2, "rd");
    check("rd byte0", rbuf[0], 8'hC3);
    check("rd byte1", rbuf[1], 8'h3C);

    // Abort: STOP after four data bits leaves the register alone.
    host_write(4'd2, 8'h77);
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h02, a);
    for (int i = 0; i < 4; i++) bit_cycle(i[0], s);
    i2c_stop();
    check("abort strobes", strobe_cnt - s0, 0);
    check("abort busy", busy, 0);
    host_read(4'd2, d); check("abort reg2", d, 8'h77);
    m_ptr = 4'd2;
    wbuf[0] = 8'h66;
    bus_write(8'hA0, 8'h02, 1, "post-abort");
    host_read(4'd2, d); check("post-abort reg2", d, 8'h66);

    // Reset while the target drives a 0 data bit.
    host_write(4'd9, 8'h3C);
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h09, a);
    i2c_start();
    write_byte(8'hA1, a);
    repeat (6) @(negedge clk);
    check("pre-reset driving", sda_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset releases sda", sda_oe, 0);
    reset = 1'b0;
    m_ptr = '0;
    check("reset busy clear", busy, 0);
    host_read(4'd9, d); check("reset keeps reg9", d, 8'h3C);
    repeat (4 * T) @(negedge clk);
    bus_read(1'b0, 8'h00, 1, "post-reset");

    // Randomized transactions against the model.
    for (int it = 0; it < 20; it++) begin
      int op, n;
      logic [7:0] dev, p;
      logic [3:0] ha;
      op = $urandom_range(0, 2);
      p  = 8'($urandom);
      if (op == 0) begin
        host_write(4'($urandom), 8'($urandom));
      end else if (op == 1) begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        dev = ($urandom_range(0, 3) == 0) ? {7'($urandom), 1'b0} : 8'hA0;
        bus_write(dev, p, n, $sformatf("rnd%0d wr", it));
      end else begin
        bus_read(1'b1, p, $urandom_range(1, 3), $sformatf("rnd%0d rd", it));
      end
      ha = 4'($urandom);
      host_read(ha, d);
      check($sformatf("rnd%0d host read", it), d, m_regs[ha]);
    end

    check("sda_oe stable while scl high", oe_hi_changes, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder: the far end of the bit-banged I2C initiator that the Forth CPU drives through its i2c port.
- Holds a small byte-wide register file. The bus accesses it with pointer-then-data transfers.
- A local host port gives the design direct access to the same registers.
- Used in the bench SoC as an on-chip I2C peripheral, and as a reference target for testing CPU I2C firmware.

Parameters:
- ADDRESS, 7'h50, 7-bit target address matched on the bus.
- REG_BITS, 4, register file has 2^REG_BITS 8-bit registers; also the pointer width.

Ports:
- clk  input  1  system clock, at least 8x the SCL rate.
- reset  input  1  synchronous, active-high reset.
- scl_in  input  1  raw SCL pin level, asynchronous.
- sda_in  input  1  raw SDA pin level, asynchronous.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- host_addr  input  REG_BITS  host register index.
- host_wdata  input  8  host write data.
- host_we  input  1  host write strobe, one cycle.
- host_rdata  output  8  registered read of reg[host_addr], 1-cycle latency.
- busy  output  1  high from a matched address until STOP or return to IDLE.
- wr_strobe  output  1  one-cycle pulse per byte written from the bus.
- wr_index  output  REG_BITS  register index of the last bus write.

Behaviour:
- Input conditioning:
  - scl_in and sda_in each pass through a 2-FF synchronizer plus a previous-value FF.
  - Edge and condition detection runs on the synchronized signals, 2-3 clk after the pin change.
- Bus condition detection:
  - START: synchronized SDA falls while SCL is high.
  - STOP: synchronized SDA rises while SCL is high.
  - Both are evaluated every cycle, in every state.
- Shift timing:
  - Data is sampled on SCL rising edges.
  - sda_oe changes only on the cycle after an SCL falling edge is detected; it never changes while SCL is high.
- State machine states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE: waits for START, then goes to ADDR with bit count 0.
- ADDR: shifts 8 bits, MSB first. On the falling edge after bit 8:
  - Upper 7 bits == ADDRESS: drive sda_oe=1, set busy, go to ADDR_ACK.
  - Otherwise: go to IGNORE with sda_oe=0.
- ADDR_ACK: on the next SCL falling edge:
  - R/W=0: release SDA, go to PTR.
  - R/W=1: drive bit 7 of reg[ptr] (sda_oe = !bit), go to RDATA.
- PTR: shifts 8 bits. The low REG_BITS bits load ptr; upper bits are ignored. Then ACK (PTR_ACK) and go to WDATA.
- WDATA: shifts 8 bits, then on the falling edge:
  - Write reg[ptr].
  - Pulse wr_strobe for one cycle, with wr_index = ptr.
  - Increment ptr modulo 2^REG_BITS (wraps from 2^REG_BITS-1 to 0).
  - ACK, then return to WDATA. Unlimited burst length.
- RDATA:
  - Drives the 8 bits MSB first; after each falling edge the next bit is presented.
  - After bit 8, release SDA and go to RDATA_ACK.
  - ptr increments (wrapping) when the 8th bit is released.
- RDATA_ACK: samples SDA on the SCL rising edge.
  - 0 (ACK): on the falling edge load reg[ptr] and drive its MSB, go to RDATA.
  - 1 (NACK): go to IGNORE.
- IGNORE: sda_oe=0; waits for START or STOP.
- Any START (repeated start) in any state: go to ADDR, sda_oe=0, bit count cleared. ptr is kept, so a write-pointer + repeated-start + read sequence works.
- Any STOP: go to IDLE, sda_oe=0, busy=0. A partially shifted byte is discarded (no register write).
- Host port:
  - host_we writes reg[host_addr] at the clock edge.
  - If a host write and a bus write hit the same register in the same cycle, the host write wins.
  - host_rdata is registered and always reads reg[host_addr] from the previous cycle.
  - A bus read byte is latched into the shift register at the start of the byte; later host writes do not alter a byte already in flight.
- Reset (synchronous, active-high, dominant):
  - State IDLE, sda_oe=0, busy=0, wr_strobe=0, wr_index=0, ptr=0, host_rdata=0, synchronizers=1.
  - The register file is NOT cleared.
  - A reset mid-transfer releases SDA on the next clk.

Test Plan:
- Address match write: START, 0xA0, ptr 0x03, data 0x5A, STOP -> ACK on all three bytes; wr_strobe pulses once with wr_index=3; host_addr=3 reads 0x5A; busy low after STOP.
- Burst write with wrap: ptr 0x0E, data 0x11 0x22 0x33 -> reg[14]=0x11, reg[15]=0x22, reg[0]=0x33; three wr_strobe pulses.
- Repeated-start read: host preloads reg[5]=0xC3, reg[6]=0x3C; sequence START A0 05 RSTART A1, master ACK, then NACK, STOP -> SDA bits read 0xC3 then 0x3C; target releases SDA after the NACK.
- Address mismatch: START, 0xA2, data 0xFF, STOP -> sda_oe stays 0 throughout; no register change; busy never asserted.
- Abort: STOP after 4 data bits of a write to ptr 2 -> reg[2] unchanged, state IDLE; a following valid transaction succeeds.
- Reset mid-read while target drives SDA low -> sda_oe=0 on the next clk; ptr=0; registers retain their values.
